// File: rtl/phase_seq_pkg.sv
// rtl/phase_seq_pkg.sv - Johnson code helpers and width derivations for phase_sequencer
package phase_seq_pkg;

   localparam int MAX_K = 16;

   function automatic int calc_k(input int num_phases);
      return num_phases / 2;
   endfunction

   function automatic int calc_idx_w(input int num_phases);
      return $clog2(num_phases);
   endfunction

   // Index s <= k sets the low s bits; s > k clears the low s-k bits of an all-ones word.
   function automatic logic [MAX_K-1:0] johnson_enc(input int idx, input int k);
      logic [MAX_K-1:0] code;
      code = '0;
      for (int b = 0; b < MAX_K; b++) begin
         if (b < k) begin
            code[b] = (idx <= k) ? (b < idx) : (b >= idx - k);
         end
      end
      return code;
   endfunction

   function automatic int johnson_dec(input logic [MAX_K-1:0] code, input int k);
      int ones;
      ones = 0;
      for (int b = 0; b < MAX_K; b++) begin
         if (b < k && code[b]) begin
            ones++;
         end
      end
      if (ones == 0) begin
         return 0;
      end else if (code[0]) begin
         return ones;
      end else begin
         return 2 * k - ones;
      end
   endfunction

   function automatic logic johnson_legal(input logic [MAX_K-1:0] code, input int k);
      return code == johnson_enc(johnson_dec(code, k), k);
   endfunction

endpackage

// File: rtl/johnson_phase_decode.sv
// rtl/johnson_phase_decode.sv - combinational Johnson code to one-hot phase and binary index
module johnson_phase_decode
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES = 8,
   localparam int K         = calc_k(NUM_PHASES),
   localparam int IDX_W     = calc_idx_w(NUM_PHASES)
) (
   input  logic [K-1:0]          i_code,
   output logic [NUM_PHASES-1:0] o_phase,
   output logic [IDX_W-1:0]      o_phase_idx
);

   logic [IDX_W-1:0] w_idx;

   assign w_idx       = IDX_W'(johnson_dec(MAX_K'(i_code), K));
   assign o_phase     = NUM_PHASES'(1) << w_idx;
   assign o_phase_idx = w_idx;

endmodule

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - Johnson-ring multi-phase generator with dwell, direction, load and recovery
module phase_sequencer
   import phase_seq_pkg::*;
#(
   parameter int NUM_PHASES = 8,
   parameter int DWELL_W    = 4,
   localparam int K         = calc_k(NUM_PHASES),
   localparam int IDX_W     = calc_idx_w(NUM_PHASES)
) (
   input  logic                  i_phase_count,
   input  logic                  i_clear,
   input  logic                  i_enable,
   input  logic                  i_dir,
   input  logic [DWELL_W-1:0]    i_dwell,
   input  logic                  i_load,
   input  logic [IDX_W-1:0]      i_load_phase,
   output logic [NUM_PHASES-1:0] o_phase,
   output logic [IDX_W-1:0]      o_phase_idx,
   output logic                  o_step,
   output logic                  o_wrap,
   output logic                  o_err
);

   logic [K-1:0]       r_state;
   logic [DWELL_W-1:0] r_dcnt;
   logic               r_step;
   logic               r_wrap;
   logic               r_err;

   logic [K-1:0]       w_state_nxt;
   logic [DWELL_W-1:0] w_dcnt_nxt;
   logic               w_step_nxt;
   logic               w_wrap_nxt;
   logic               w_err_nxt;
   logic [K-1:0]       w_adv_code;
   logic [IDX_W-1:0]   w_idx;
   logic               w_legal;
   logic               w_due;
   logic               w_load_ok;
   logic               w_wrap_edge;

   johnson_phase_decode #(
      .NUM_PHASES (NUM_PHASES)
   ) u_decode (
      .i_code      (r_state),
      .o_phase     (o_phase),
      .o_phase_idx (w_idx)
   );

   assign w_legal     = johnson_legal(MAX_K'(r_state), K);
   assign w_due       = i_enable && (r_dcnt >= i_dwell);
   assign w_load_ok   = i_load && (32'(i_load_phase) < NUM_PHASES);
   assign w_adv_code  = i_dir ? {~r_state[0], r_state[K-1:1]}
                              : {r_state[K-2:0], ~r_state[K-1]};
   assign w_wrap_edge = i_dir ? (w_idx == '0) : (w_idx == IDX_W'(NUM_PHASES - 1));

   // Recovery outranks load, which outranks a due advance.
   always_comb begin
      w_state_nxt = r_state;
      w_dcnt_nxt  = r_dcnt;
      w_step_nxt  = 1'b0;
      w_wrap_nxt  = 1'b0;
      w_err_nxt   = r_err;
      if (!w_legal) begin
         w_state_nxt = '0;
         w_dcnt_nxt  = '0;
         w_err_nxt   = 1'b1;
      end else if (w_load_ok) begin
         w_state_nxt = K'(johnson_enc(32'(i_load_phase), K));
         w_dcnt_nxt  = '0;
      end else begin
         if (i_load) begin
            w_err_nxt = 1'b1;
         end
         if (w_due) begin
            w_state_nxt = w_adv_code;
            w_dcnt_nxt  = '0;
            w_step_nxt  = 1'b1;
            w_wrap_nxt  = w_wrap_edge;
         end else if (i_enable) begin
            w_dcnt_nxt = r_dcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_phase_count) begin
      if (i_clear) begin
         r_state <= '0;
         r_dcnt  <= '0;
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_step  <= w_step_nxt;
         r_wrap  <= w_wrap_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign o_phase_idx = w_idx;
   assign o_step      = r_step;
   assign o_wrap      = r_wrap;
   assign o_err       = r_err;

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer
module tb_phase_sequencer;

   logic       clk = 1'b0;
   logic       clear, enable, dir, load;
   logic [3:0] dwell;
   logic [2:0] load_phase;
   logic [7:0] phase;
   logic [2:0] phase_idx;
   logic       step, wrap, err;

   logic       c6_clear, c6_load;
   logic [2:0] c6_lp;
   logic [5:0] c6_phase;
   logic [2:0] c6_idx;
   logic       c6_step, c6_wrap, c6_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   phase_sequencer #(.NUM_PHASES(8), .DWELL_W(4)) dut (
      .i_phase_count (clk),
      .i_clear       (clear),
      .i_enable      (enable),
      .i_dir         (dir),
      .i_dwell       (dwell),
      .i_load        (load),
      .i_load_phase  (load_phase),
      .o_phase       (phase),
      .o_phase_idx   (phase_idx),
      .o_step        (step),
      .o_wrap        (wrap),
      .o_err         (err)
   );

   phase_sequencer #(.NUM_PHASES(6), .DWELL_W(4)) dut6 (
      .i_phase_count (clk),
      .i_clear       (c6_clear),
      .i_enable      (enable),
      .i_dir         (dir),
      .i_dwell       (dwell),
      .i_load        (c6_load),
      .i_load_phase  (c6_lp),
      .o_phase       (c6_phase),
      .o_phase_idx   (c6_idx),
      .o_step        (c6_step),
      .o_wrap        (c6_wrap),
      .o_err         (c6_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect8(input string tag, input logic [7:0] ph, input logic st,
                          input logic wr, input logic er);
      logic [31:0] idx;
      idx = 0;
      for (int i = 0; i < 8; i++) if (ph[i]) idx = i;
      chk({tag, ".phase"}, 32'(phase), 32'(ph));
      chk({tag, ".idx"},   32'(phase_idx), idx);
      chk({tag, ".step"},  32'(step), 32'(st));
      chk({tag, ".wrap"},  32'(wrap), 32'(wr));
      chk({tag, ".err"},   32'(err), 32'(er));
   endtask

   task automatic expect6(input string tag, input logic [5:0] ph, input logic st,
                          input logic wr, input logic er);
      chk({tag, ".phase"}, 32'(c6_phase), 32'(ph));
      chk({tag, ".step"},  32'(c6_step), 32'(st));
      chk({tag, ".wrap"},  32'(c6_wrap), 32'(wr));
      chk({tag, ".err"},   32'(c6_err), 32'(er));
   endtask

   initial begin
      clear = 1'b1; enable = 1'b0; dir = 1'b0; load = 1'b0;
      dwell = 4'd0; load_phase = 3'd0;
      c6_clear = 1'b1; c6_load = 1'b0; c6_lp = 3'd0;
      tick();
      clear = 1'b0; c6_clear = 1'b0;
      expect8("reset", 8'h01, 1'b0, 1'b0, 1'b0);

      // free run, Dwell=0
      enable = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tick();
         expect8("free", 8'(1 << (i % 8)), 1'b1, (i == 8), 1'b0);
      end
      tick();
      expect8("free_after_wrap", 8'h02, 1'b1, 1'b0, 1'b0);

      // dwell 2: three enabled cycles per phase
      clear = 1'b1;
      tick();
      clear = 1'b0; dwell = 4'd2;
      for (int p = 0; p < 3; p++) begin
         tick(); expect8("dwell_a", 8'(1 << p), 1'b0, 1'b0, 1'b0);
         tick(); expect8("dwell_b", 8'(1 << p), 1'b0, 1'b0, 1'b0);
         tick(); expect8("dwell_adv", 8'(1 << (p + 1)), 1'b1, 1'b0, 1'b0);
      end
      tick(); expect8("ph3_first", 8'h08, 1'b0, 1'b0, 1'b0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(); expect8("hold", 8'h08, 1'b0, 1'b0, 1'b0);
      end
      enable = 1'b1;
      tick(); expect8("resume", 8'h08, 1'b0, 1'b0, 1'b0);
      tick(); expect8("resume_adv", 8'h10, 1'b1, 1'b0, 1'b0);

      // down run and mid-phase direction change
      clear = 1'b1;
      tick();
      clear = 1'b0; dwell = 4'd0; dir = 1'b1;
      tick(); expect8("down_wrap", 8'h80, 1'b1, 1'b1, 1'b0);
      tick(); expect8("down_6", 8'h40, 1'b1, 1'b0, 1'b0);
      dir = 1'b0;
      tick(); expect8("up_7", 8'h80, 1'b1, 1'b0, 1'b0);
      tick(); expect8("up_wrap", 8'h01, 1'b1, 1'b1, 1'b0);

      // load overrides a due advance (Dwell lowered below dcnt)
      dwell = 4'd5;
      for (int i = 0; i < 3; i++) begin
         tick(); expect8("pre_load", 8'h01, 1'b0, 1'b0, 1'b0);
      end
      dwell = 4'd1; load = 1'b1; load_phase = 3'd5;
      tick(); expect8("load5", 8'h20, 1'b0, 1'b0, 1'b0);
      load = 1'b0;
      tick(); expect8("load_dcnt0", 8'h20, 1'b0, 1'b0, 1'b0);
      tick(); expect8("load_adv", 8'h40, 1'b1, 1'b0, 1'b0);
      dwell = 4'd5;
      for (int i = 0; i < 3; i++) begin
         tick(); expect8("ge_wait", 8'h40, 1'b0, 1'b0, 1'b0);
      end
      dwell = 4'd1;
      tick(); expect8("ge_adv", 8'h80, 1'b1, 1'b0, 1'b0);

      // illegal-state recovery (K=4 code 0101)
      enable = 1'b0;
      force dut.r_state = 4'b0101;
      tick();
      release dut.r_state;
      chk("recover_err", 32'(err), 32'd1);
      tick(); expect8("recovered", 8'h01, 1'b0, 1'b0, 1'b1);
      enable = 1'b1; dwell = 4'd0;
      tick(); expect8("recover_run", 8'h02, 1'b1, 1'b0, 1'b1);

      // Clear mid-dwell beats Load and Enable
      dwell = 4'd3;
      tick(); tick();
      clear = 1'b1; load = 1'b1; load_phase = 3'd5;
      tick();
      clear = 1'b0; load = 1'b0; enable = 1'b0;
      expect8("mid_clear", 8'h01, 1'b0, 1'b0, 1'b0);

      // out-of-range load on a 6-phase instance
      c6_clear = 1'b1;
      tick();
      c6_clear = 1'b0; c6_load = 1'b1; c6_lp = 3'd4; dwell = 4'd0;
      tick(); expect6("c6_load4", 6'h10, 1'b0, 1'b0, 1'b0);
      c6_lp = 3'd7; enable = 1'b1;
      tick(); expect6("c6_bad_load", 6'h20, 1'b1, 1'b0, 1'b1);
      c6_load = 1'b0;
      tick(); expect6("c6_wrap", 6'h01, 1'b1, 1'b1, 1'b1);
      tick(); expect6("c6_sticky", 6'h02, 1'b1, 1'b0, 1'b1);
      c6_clear = 1'b1;
      tick(); expect6("c6_clear", 6'h01, 1'b0, 1'b0, 1'b0);
      c6_clear = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
